// File: rtl/uart_tx.sv
// uart_tx: 8-bit serial transmitter, LSB first, optional even parity, one stop bit.
// The line, busy and done outputs are registered from the current state and trail it by one clock.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    // Line level driven for each state; unknown encodings idle high.
    function automatic logic line_level(input state_t st, input logic lsb, input logic par);
        logic lvl;
        case (st)
            IDLE:    lvl = 1'b1;
            START:   lvl = 1'b0;
            DATA:    lvl = lsb;
            PARITY:  lvl = par;
            STOP:    lvl = 1'b1;
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

    state_t      state_r;
    logic [15:0] baud_r;
    logic [2:0]  idx_r;
    logic [7:0]  shift_r;
    logic [7:0]  data_r;
    logic        stop_end_r;
    logic        tx_r;
    logic        busy_r;
    logic        done_r;
    logic        bit_end_s;
    logic        accept_s;

    // Bit-end and request-acceptance decode.
    always_comb begin
        bit_end_s = (baud_r == BAUD_LAST);
        if (state_r == IDLE) begin
            // A request coinciding with the done pulse is dropped.
            accept_s = i_start && !done_r;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Frame sequencer plus registered line/busy/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_r     <= 16'd0;
            idx_r      <= 3'd0;
            shift_r    <= 8'd0;
            data_r     <= 8'd0;
            stop_end_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            tx_r       <= line_level(state_r, shift_r[0], even_parity(data_r));
            busy_r     <= (state_r != IDLE);
            done_r     <= stop_end_r;
            stop_end_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shift_r <= i_data;
                        data_r  <= i_data;
                        baud_r  <= 16'd0;
                        idx_r   <= 3'd0;
                        state_r <= START;
                    end else begin
                        baud_r  <= 16'd0;
                        idx_r   <= 3'd0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        baud_r  <= 16'd0;
                        state_r <= DATA;
                    end else begin
                        baud_r  <= baud_r + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_r  <= 16'd0;
                        shift_r <= {1'b0, shift_r[7:1]};
                        idx_r   <= idx_r + 3'd1;
                        if (idx_r == 3'd7) begin
                            state_r <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        baud_r  <= baud_r + 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        baud_r  <= 16'd0;
                        state_r <= STOP;
                    end else begin
                        baud_r  <= baud_r + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        baud_r     <= 16'd0;
                        stop_end_r <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        baud_r     <= baud_r + 16'd1;
                    end
                end
                default: begin
                    baud_r  <= 16'd0;
                    idx_r   <= 3'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_tx   = tx_r;
    assign o_busy = busy_r;
    assign o_done = done_r;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_start  input  1  request to transmit i_data; sampled only in IDLE.
REQ-006 i_data  input  8  byte to transmit; captured on the cycle the request is accepted.
REQ-007 o_tx  output  1  serial line; idle level is 1.
REQ-008 o_busy  output  1  high from the cycle after acceptance until the frame completes.
REQ-009 o_done  output  1  single-cycle pulse at frame completion.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP; the encoding is free, and illegal encodings SHALL return to IDLE on the next clock.
REQ-011 In IDLE: o_tx=1 and o_busy=0; i_start=1 SHALL latch i_data into an 8-bit shift register, clear the baud counter and bit index, and move to START.
REQ-012 o_tx SHALL be registered, so the line changes one clock after the state or bit change; the start bit appears on o_tx in the cycle after acceptance.
REQ-013 The baud counter SHALL count 0..CLKS_PER_BIT-1 in every non-IDLE state; the bit ends on the cycle the counter equals CLKS_PER_BIT-1, and the counter then wraps to 0.
REQ-014 In START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-015 In DATA: o_tx = the current LSB of the shift register, sent LSB first. At each bit end the register SHALL shift right and the 3-bit index SHALL increment. After index 7 ends, go to PARITY if PARITY_EN=1, otherwise go to STOP.
REQ-016 In PARITY: o_tx = XOR of the 8 latched data bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
REQ-017 In STOP: o_tx=1 for CLKS_PER_BIT cycles. At the end of the stop bit, o_done=1 for exactly that one cycle and the state returns to IDLE.
REQ-018 Frame length SHALL be exactly (10+PARITY_EN)*CLKS_PER_BIT cycles of o_tx activity.
REQ-019 i_start while o_busy=1 SHALL be ignored; no queuing, and the in-flight frame is unaffected.
REQ-020 i_start asserted in the same cycle o_done is high SHALL be ignored. A new request is accepted no earlier than the next cycle, while in IDLE.
REQ-021 Changes on i_data after acceptance SHALL NOT affect the frame in progress.
REQ-022 i_start held continuously high SHALL produce back-to-back frames, each separated by exactly one IDLE cycle with o_tx=1.

Reset
REQ-023 While rst=1: state=IDLE, o_tx=1, o_busy=0, o_done=0, baud counter=0, bit index=0, shift register=0.
REQ-024 rst asserted mid-frame SHALL force o_tx=1 immediately, without waiting for clk. The aborted frame SHALL NOT produce o_done.
REQ-025 After rst deasserts, the first rising clk edge SHALL evaluate IDLE normally, so i_start high at that edge is accepted.

Verification
REQ-026 CLKS_PER_BIT=4, PARITY_EN=0, i_data=8'hA5, one-cycle i_start -> o_tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; o_done pulses once, 40 cycles after o_tx first goes low.
REQ-027 CLKS_PER_BIT=4, PARITY_EN=1, i_data=8'h07 -> parity bit=1; frame is 44 cycles; stop bit follows the parity bit.
REQ-028 i_start pulsed at cycles 5 and 20 of a frame with i_data=8'hFF -> both ignored; the original byte is sent unchanged; one o_done only.
REQ-029 i_start held high with i_data=8'h00 then 8'h81 -> two frames with exactly one idle-high cycle between them; second frame data bits are 1,0,0,0,0,0,0,1.
REQ-030 rst asserted during DATA bit 3 -> o_tx=1 and o_busy=0 asynchronously, no o_done. The next i_start sends a complete, correct frame.
REQ-031 CLKS_PER_BIT=2 (minimum), i_data=8'h55 -> each bit lasts exactly 2 cycles; no dropped or duplicated bits.
